// File: rtl/md_issue_ctrl.sv
// E-stage requester for the multiply/divide unit: decodes MD instructions, issues
// start/write pulses, tracks the outstanding operation and stalls dependent D-stage reads.
module md_issue_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Req,
  input  logic [31:0]      E_Instr,
  input  logic [31:0]      E_rs,
  input  logic [31:0]      E_rt,
  input  logic [31:0]      D_Instr,
  input  logic             md_busy,
  input  logic [31:0]      md_hi,
  input  logic [31:0]      md_lo,
  output logic             md_start,
  output logic             md_we,
  output logic [2:0]       md_op,
  output logic [31:0]      md_a,
  output logic [31:0]      md_b,
  output logic             stall_d,
  output logic [31:0]      e_md_rdata,
  output logic             e_md_rvalid,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUED = 2'd1, WAIT = 2'd2} state_t;

  state_t           state_reg, state_next;
  logic [WD_W-1:0]  wdog_reg, wdog_next;
  logic             md_err_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             timeout_hit;

  logic       e_rtype, d_rtype;
  logic [5:0] e_funct, d_funct;
  logic       e_is_muldiv, e_is_mt, e_is_mf, d_is_md;
  logic [2:0] e_op;

  assign e_rtype = (E_Instr[31:26] == 6'd0);
  assign d_rtype = (D_Instr[31:26] == 6'd0);
  assign e_funct = E_Instr[5:0];
  assign d_funct = D_Instr[5:0];

  assign e_is_muldiv = e_rtype && (e_funct >= 6'h18) && (e_funct <= 6'h1B);
  assign e_is_mt     = e_rtype && ((e_funct == 6'h11) || (e_funct == 6'h13));
  assign e_is_mf     = e_rtype && ((e_funct == 6'h10) || (e_funct == 6'h12));
  assign d_is_md     = d_rtype && (((d_funct >= 6'h18) && (d_funct <= 6'h1B)) ||
                                   (d_funct == 6'h10) || (d_funct == 6'h11) ||
                                   (d_funct == 6'h12) || (d_funct == 6'h13));

  always_comb begin
    case (e_funct)
      6'h18:   e_op = 3'd0;
      6'h19:   e_op = 3'd1;
      6'h1A:   e_op = 3'd2;
      6'h1B:   e_op = 3'd3;
      6'h11:   e_op = 3'd4;
      6'h13:   e_op = 3'd5;
      default: e_op = 3'd7;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      wdog_reg      <= '0;
      md_err_reg    <= 1'b0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      wdog_reg  <= wdog_next;
      if (timeout_hit) begin
        md_err_reg <= 1'b1;
      end
      if (stall_d && (stall_cnt_reg != {CNT_W{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  // A normal busy-drop exit takes priority over the watchdog on the same cycle.
  always_comb begin
    state_next  = state_reg;
    wdog_next   = wdog_reg;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        if (md_start) begin
          state_next = ISSUED;
        end
      end
      ISSUED: begin
        state_next = WAIT;
        wdog_next  = '0;
      end
      WAIT: begin
        if (!md_busy) begin
          state_next = IDLE;
        end else if (wdog_reg == WD_LAST) begin
          state_next  = IDLE;
          timeout_hit = 1'b1;
        end else begin
          wdog_next = wdog_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    md_start    = e_is_muldiv && !Req && (state_reg == IDLE);
    md_we       = e_is_mt && !Req;
    md_op       = (md_start || md_we) ? e_op : 3'd7;
    md_a        = E_rs;
    md_b        = E_rt;
    stall_d     = d_is_md && !Req && ((state_reg != IDLE) || md_start || md_busy);
    e_md_rvalid = e_is_mf;
    e_md_rdata  = 32'd0;
    if (e_is_mf) begin
      e_md_rdata = (e_funct == 6'h10) ? md_hi : md_lo;
    end
    md_err      = md_err_reg;
    stall_cnt   = stall_cnt_reg;
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed self-checking bench for md_issue_ctrl; inputs change on the falling edge
// and combinational outputs are sampled 1 ns later, well before the next rising edge.
module tb_md_issue_ctrl;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  localparam logic [31:0] I_MULT  = 32'h0000_0018;
  localparam logic [31:0] I_MULTU = 32'h0000_0019;
  localparam logic [31:0] I_DIV   = 32'h0000_001A;
  localparam logic [31:0] I_DIVU  = 32'h0000_001B;
  localparam logic [31:0] I_MTHI  = 32'h0000_0011;
  localparam logic [31:0] I_MTLO  = 32'h0000_0013;
  localparam logic [31:0] I_MFHI  = 32'h0000_0010;
  localparam logic [31:0] I_MFLO  = 32'h0000_0012;
  localparam logic [31:0] I_ADDU  = 32'h0043_1021;
  localparam logic [31:0] I_FAKE  = 32'h0400_0018;

  logic             clk = 1'b0;
  logic             reset;
  logic             Req;
  logic [31:0]      E_Instr, E_rs, E_rt, D_Instr;
  logic             md_busy;
  logic [31:0]      md_hi, md_lo;
  logic             md_start, md_we, stall_d, e_md_rvalid, md_err;
  logic [2:0]       md_op;
  logic [31:0]      md_a, md_b, e_md_rdata;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  md_issue_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Req(Req),
    .E_Instr(E_Instr), .E_rs(E_rs), .E_rt(E_rt), .D_Instr(D_Instr),
    .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo),
    .md_start(md_start), .md_we(md_we), .md_op(md_op),
    .md_a(md_a), .md_b(md_b), .stall_d(stall_d),
    .e_md_rdata(e_md_rdata), .e_md_rvalid(e_md_rvalid),
    .md_err(md_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] e, input logic [31:0] d, input logic busy, input logic rq);
    @(negedge clk);
    E_Instr = e; D_Instr = d; md_busy = busy; Req = rq;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; Req = 1'b0; E_Instr = '0; E_rs = '0; E_rt = '0; D_Instr = '0;
    md_busy = 1'b0; md_hi = '0; md_lo = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (md_start !== 1'b0) begin failures++; $display("FAIL rst_start got=%0b exp=0", md_start); end
    checks++; if (md_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%0b exp=0", md_we); end
    checks++; if (md_op !== 3'd7) begin failures++; $display("FAIL rst_op got=%0d exp=7", md_op); end
    checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", stall_d); end
    checks++; if (md_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%0b exp=0", md_err); end
    checks++; if (stall_cnt !== '0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (e_md_rvalid !== 1'b0 || e_md_rdata !== 32'd0) begin failures++;
      $display("FAIL rst_rd got=%0b/%h exp=0/0", e_md_rvalid, e_md_rdata); end
    $display("reset: outputs checked");
  endtask

  task automatic test_mult_issue();
    E_rs = 32'd3; E_rt = 32'hFFFF_FFFE;
    drive(I_MULT, I_MFHI, 1'b0, 1'b0);
    checks++; if (md_start !== 1'b1) begin failures++; $display("FAIL mult_start got=%0b exp=1", md_start); end
    checks++; if (md_op !== 3'd0) begin failures++; $display("FAIL mult_op got=%0d exp=0", md_op); end
    checks++; if (md_a !== 32'd3 || md_b !== 32'hFFFF_FFFE) begin failures++;
      $display("FAIL mult_ab got=%h/%h exp=00000003/fffffffe", md_a, md_b); end
    checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL mult_stall0 got=%0b exp=1", stall_d); end
    // ISSUED: a held multiply must not restart, and the read still stalls with busy low
    drive(I_MULT, I_MFHI, 1'b0, 1'b0);
    checks++; if (md_start !== 1'b0 || md_op !== 3'd7) begin failures++;
      $display("FAIL mult_issued_start got=%0b/%0d exp=0/7", md_start, md_op); end
    checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL mult_stall_issued got=%0b exp=1", stall_d); end
    drive(32'd0, I_MFHI, 1'b0, 1'b0);
    checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL mult_stall_wait got=%0b exp=1", stall_d); end
    drive(32'd0, I_MFHI, 1'b0, 1'b0);
    checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL mult_stall_idle got=%0b exp=0", stall_d); end
    checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL mult_cnt got=%0d exp=3", stall_cnt); end
    $display("mult: issue and ISSUED/WAIT sequence checked");
  endtask

  task automatic test_div_stall();
    do_reset();
    E_rs = 32'd100; E_rt = 32'd7; md_hi = 32'hDEAD_0001; md_lo = 32'hCAFE_0002;
    drive(I_DIV, I_MFLO, 1'b0, 1'b0);
    checks++; if (md_start !== 1'b1 || md_op !== 3'd2) begin failures++;
      $display("FAIL div_start got=%0b/%0d exp=1/2", md_start, md_op); end
    for (int c = 1; c <= 11; c++) begin
      drive(32'd0, I_MFLO, 1'b1, 1'b0);
      checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL div_stall_busy c=%0d got=%0b exp=1", c, stall_d); end
    end
    drive(32'd0, I_MFLO, 1'b0, 1'b0);
    checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL div_stall_tail got=%0b exp=1", stall_d); end
    drive(32'd0, I_MFLO, 1'b0, 1'b0);
    checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL div_stall_release got=%0b exp=0", stall_d); end
    checks++; if (stall_cnt !== 16'd13) begin failures++; $display("FAIL div_cnt got=%0d exp=13", stall_cnt); end
    drive(I_MFLO, 32'd0, 1'b0, 1'b0);
    checks++; if (e_md_rvalid !== 1'b1 || e_md_rdata !== 32'hCAFE_0002) begin failures++;
      $display("FAIL div_mflo got=%0b/%h exp=1/cafe0002", e_md_rvalid, e_md_rdata); end
    drive(I_MFHI, 32'd0, 1'b0, 1'b0);
    checks++; if (e_md_rvalid !== 1'b1 || e_md_rdata !== 32'hDEAD_0001) begin failures++;
      $display("FAIL div_mfhi got=%0b/%h exp=1/dead0001", e_md_rvalid, e_md_rdata); end
    checks++; if (stall_cnt !== 16'd13) begin failures++; $display("FAIL div_cnt_hold got=%0d exp=13", stall_cnt); end
    $display("div: stall window and mflo/mfhi read checked");
  endtask

  task automatic test_req_suppress();
    drive(I_MULTU, I_MFHI, 1'b0, 1'b1);
    checks++; if (md_start !== 1'b0 || md_op !== 3'd7) begin failures++;
      $display("FAIL req_multu got=%0b/%0d exp=0/7", md_start, md_op); end
    checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL req_stall got=%0b exp=0", stall_d); end
    drive(32'd0, I_MFHI, 1'b0, 1'b0);
    checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL req_still_idle got=%0b exp=0", stall_d); end
    drive(I_MTHI, 32'd0, 1'b0, 1'b1);
    checks++; if (md_we !== 1'b0 || md_op !== 3'd7) begin failures++;
      $display("FAIL req_mthi got=%0b/%0d exp=0/7", md_we, md_op); end
    drive(I_MTHI, 32'd0, 1'b0, 1'b0);
    checks++; if (md_we !== 1'b1 || md_op !== 3'd4) begin failures++;
      $display("FAIL mthi got=%0b/%0d exp=1/4", md_we, md_op); end
    checks++; if (md_start !== 1'b0) begin failures++; $display("FAIL mthi_start got=%0b exp=0", md_start); end
    $display("req: suppression of multu/mthi checked");
  endtask

  task automatic test_req_in_wait();
    drive(I_MULT, 32'd0, 1'b0, 1'b0);
    checks++; if (md_start !== 1'b1) begin failures++; $display("FAIL rqw_start got=%0b exp=1", md_start); end
    drive(32'd0, 32'd0, 1'b1, 1'b0);
    drive(32'd0, I_MFHI, 1'b1, 1'b1);
    checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL rqw_req_stall got=%0b exp=0", stall_d); end
    drive(32'd0, I_MFHI, 1'b1, 1'b1);
    drive(32'd0, I_MFHI, 1'b0, 1'b0);
    checks++; if (stall_d !== 1'b1) begin failures++; $display("FAIL rqw_wait_stall got=%0b exp=1", stall_d); end
    drive(32'd0, I_MFHI, 1'b0, 1'b0);
    checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL rqw_idle got=%0b exp=0", stall_d); end
    checks++; if (md_err !== 1'b0) begin failures++; $display("FAIL rqw_err got=%0b exp=0", md_err); end
    $display("req_in_wait: operation not cancelled");
  endtask

  task automatic test_timeout();
    drive(I_DIVU, 32'd0, 1'b0, 1'b0);
    checks++; if (md_start !== 1'b1 || md_op !== 3'd3) begin failures++;
      $display("FAIL to_start got=%0b/%0d exp=1/3", md_start, md_op); end
    for (int c = 1; c <= TIMEOUT; c++) drive(32'd0, 32'd0, 1'b1, 1'b0);
    // last WAIT cycle: still busy-waiting, no error yet
    drive(I_MULT, 32'd0, 1'b1, 1'b0);
    checks++; if (md_start !== 1'b0 || md_err !== 1'b0) begin failures++;
      $display("FAIL to_last_wait got=%0b/%0b exp=0/0", md_start, md_err); end
    drive(I_MULT, 32'd0, 1'b1, 1'b0);
    checks++; if (md_err !== 1'b1) begin failures++; $display("FAIL to_err got=%0b exp=1", md_err); end
    checks++; if (md_start !== 1'b1) begin failures++; $display("FAIL to_idle_start got=%0b exp=1", md_start); end
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    drive(32'd0, 32'd0, 1'b0, 1'b0);
    checks++; if (md_err !== 1'b1) begin failures++; $display("FAIL to_sticky got=%0b exp=1", md_err); end
    do_reset();
    #1;
    checks++; if (md_err !== 1'b0) begin failures++; $display("FAIL to_reset_clear got=%0b exp=0", md_err); end
    $display("timeout: watchdog error raised and cleared by reset");
  endtask

  task automatic test_nonmd_d();
    E_rs = 32'h0000_1234;
    drive(I_MULT, 32'd0, 1'b0, 1'b0);
    drive(32'd0, 32'd0, 1'b1, 1'b0);
    drive(32'd0, I_ADDU, 1'b1, 1'b0);
    checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL nonmd_addu got=%0b exp=0", stall_d); end
    drive(32'd0, I_FAKE, 1'b1, 1'b0);
    checks++; if (stall_d !== 1'b0) begin failures++; $display("FAIL nonmd_opcode got=%0b exp=0", stall_d); end
    drive(I_MTLO, I_ADDU, 1'b1, 1'b0);
    checks++; if (md_we !== 1'b1 || md_op !== 3'd5 || md_a !== 32'h0000_1234) begin failures++;
      $display("FAIL mtlo got=%0b/%0d/%h exp=1/5/00001234", md_we, md_op, md_a); end
    drive(I_FAKE, 32'd0, 1'b0, 1'b0);
    drive(I_FAKE, 32'd0, 1'b0, 1'b0);
    checks++; if (md_start !== 1'b0 || md_op !== 3'd7) begin failures++;
      $display("FAIL fake_e got=%0b/%0d exp=0/7", md_start, md_op); end
    $display("nonmd: D non-MD never stalls, mtlo write checked");
  endtask

  initial begin
    test_reset();
    test_mult_issue();
    test_div_stall();
    test_req_suppress();
    test_req_in_wait();
    test_timeout();
    test_nonmd_d();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Requester-side controller for the pipeline's multiply/divide unit; sits in the E stage between the pipeline registers and the MD unit.
- Decodes the E-stage instruction and issues start, opcode and operands to the MD unit. Gates issue on the interrupt/exception request.
- Tracks the outstanding operation with an FSM and produces the D-stage stall for MD-dependent instructions.
- Returns HI/LO for mfhi/mflo, runs a watchdog on the MD busy line and counts stall cycles.

Parameters:
- TIMEOUT, 64, max WAIT-state cycles before md_err is raised; must be ≥ 16.
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- Req  in  1  interrupt/exception request; the E-stage instruction must not take effect
- E_Instr  in  32  instruction in the E stage
- E_rs  in  32  forwarded rs value in E
- E_rt  in  32  forwarded rt value in E
- D_Instr  in  32  instruction in the D stage
- md_busy  in  1  busy from the MD unit
- md_hi  in  32  HI from the MD unit
- md_lo  in  32  LO from the MD unit
- md_start  out  1  one-cycle start pulse for mult/multu/div/divu
- md_we  out  1  one-cycle write pulse for mthi/mtlo
- md_op  out  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 7 none
- md_a  out  32  operand A = E_rs
- md_b  out  32  operand B = E_rt
- stall_d  out  1  freeze the D stage
- e_md_rdata  out  32  mfhi/mflo result in E
- e_md_rvalid  out  1  E holds mfhi/mflo
- md_err  out  1  sticky watchdog error
- stall_cnt  out  CNT_W  saturating count of stall_d cycles

Behaviour:
- Decode applies only when opcode == 0. Funct values: mult 0x18, multu 0x19, div 0x1A, divu 0x1B, mthi 0x11, mtlo 0x13, mfhi 0x10, mflo 0x12. Any other instruction is non-MD.
- "Class MD" means any of the eight instructions above.
- Reset values:
  - state = IDLE, wdog = 0, md_err = 0, stall_cnt = 0.
  - All outputs are combinational from these, so every output is 0 except md_op = 7.
- FSM states: IDLE, ISSUED, WAIT.
  - IDLE -> ISSUED when md_start = 1.
  - ISSUED -> WAIT unconditionally after 1 cycle. This covers the MD unit's one-cycle busy rise latency.
  - WAIT -> IDLE when md_busy = 0.
  - WAIT -> IDLE when wdog == TIMEOUT-1. In this case md_err is set and stays set until reset.
- wdog:
  - Cleared on entry to WAIT.
  - Increments each WAIT cycle while md_busy = 1.
- md_start = E is mult/multu/div/divu AND !Req AND state == IDLE. It is combinational and lasts exactly one cycle per instruction, because stall_d prevents a second MD instruction from reaching E.
- md_we = E is mthi/mtlo AND !Req. mthi/mtlo do not change the FSM state.
- md_op:
  - Follows E decode whenever md_start or md_we is 1.
  - Otherwise 7.
- md_a and md_b always equal E_rs and E_rt.
- stall_d = D is class MD AND !Req AND (state != IDLE OR md_start = 1 OR md_busy = 1).
  - When stall_d = 1, the E stage receives a bubble.
  - Non-MD instructions in D never stall.
- Req behaviour:
  - Req in the cycle E holds an MD instruction suppresses md_start and md_we; the FSM stays IDLE.
  - Req arriving while in ISSUED/WAIT does not cancel: the FSM continues and the result commits in the MD unit.
- e_md_rvalid = E is mfhi/mflo.
  - e_md_rdata = md_hi for mfhi, md_lo for mflo.
  - e_md_rdata = 0 otherwise.
  - Reads are never issued while busy, because the stall covers this.
- stall_cnt increments on each cycle with stall_d = 1. It saturates at all-ones and is cleared only by reset.
- Reset mid-operation: state returns to IDLE immediately and md_err clears. The MD unit is reset by the same signal.
- Simultaneous WAIT exit and D-stage MD instruction: when md_busy falls, stall_d drops in the same cycle only if state has already returned to IDLE. Stall therefore persists for 1 cycle after md_busy = 0.

Test Plan:
- E = mult (0x00000018), E_rs = 3, E_rt = -2, Req = 0 -> md_start pulse 1 cycle, md_op = 0, md_a = 3, md_b = 0xFFFFFFFE. State sequence ISSUED, then WAIT.
- Issue div; D = mflo held; md_busy high 11 cycles -> stall_d = 1 from issue until 1 cycle after md_busy falls. stall_cnt = 13. E then gives e_md_rdata = md_lo.
- E = multu with Req = 1 -> md_start = 0, md_op = 7, state stays IDLE. Repeat with mthi -> md_we = 0.
- Issue mult; assert Req in the WAIT state -> FSM still reaches IDLE when md_busy = 0; md_err = 0.
- Issue divu with md_busy stuck at 1 -> md_err rises after TIMEOUT WAIT cycles; state = IDLE; md_err stays 1 until reset, then reads 0.
- Non-MD in D (addu) while in WAIT -> stall_d = 0. E = mtlo with E_rs = 0x1234 -> md_we = 1, md_op = 5, md_a = 0x1234.
